apuf_eval_ctrl: RTL and testbench

- Sequencing controller for a multi-chain arbiter PUF.
- Latches a challenge and derives one challenge per delay chain by rotation.
- Generates the launch edge and samples each chain's arbiter bit through a 2-flop synchroniser.
- Optionally majority-votes repeated evaluations, then returns a per-chain or XOR-reduced response with a done pulse.
- Sits between the challenge source (UART/host logic) and N_CHAINS instances of the delay-chain + arbiter pair.

---
 rtl/apuf_pkg.sv | 22 ++
 rtl/apuf_sync2.sv | 32 +++
 rtl/apuf_eval_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_apuf_eval_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apuf_pkg.sv
// Shared definitions for the arbiter-PUF evaluation controller: FSM state
// encoding, a constant-expression clog2 helper and default chain geometry.
package apuf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        FIRE = 2'd2,
        DONE = 2'd3
    } apuf_state_t;

    localparam int C_LENGTH_DEF = 64;
    localparam int N_CHAINS_DEF = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result = result + 1;
        return result;
    endfunction

endpackage

// File: rtl/apuf_sync2.sv
// Two-flop synchroniser for one asynchronous arbiter output bit; both flops
// carry ASYNC_REG so implementation keeps them adjacent and untouched.
module apuf_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic meta_q;
    (* ASYNC_REG = "TRUE" *) logic sync_q;
    logic meta_d;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/apuf_eval_ctrl.sv
// Sequencing controller for a multi-chain arbiter PUF: latch, settle, launch,
// sample, optional majority vote. Define APUF_MAJORITY_VOTE_EN for N_EVAL-fold voting.
module apuf_eval_ctrl
    import apuf_pkg::*;
#(
    parameter int C_LENGTH      = C_LENGTH_DEF,
    parameter int N_CHAINS      = N_CHAINS_DEF,
    parameter int SETTLE_CYCLES = 4,
    parameter int N_EVAL        = 5
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         Start,
    input  logic                         Mode,
    input  logic [C_LENGTH-1:0]          Challenge,
    output logic                         Busy,
    output logic                         Done,
    output logic [N_CHAINS-1:0]          Response,
    output logic                         Launch,
    output logic [N_CHAINS*C_LENGTH-1:0] Chain_challenge,
    input  logic [N_CHAINS-1:0]          Arb_in
);

    localparam int                 PHASE_W    = clog2(SETTLE_CYCLES);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 3 || N_EVAL < 1 || (N_EVAL % 2) == 0) begin : g_bad_params
        $error("apuf_eval_ctrl: SETTLE_CYCLES must be >= 3 and N_EVAL odd and >= 1");
    end

    apuf_state_t         state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [C_LENGTH-1:0] challenge_q, challenge_d;
    logic                mode_q, mode_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                launch_q, launch_d;
    logic [N_CHAINS-1:0] response_q, response_d;
    logic [N_CHAINS-1:0] arb_sync;
    logic [N_CHAINS-1:0] vote_bits;
    logic                last_eval;

    for (genvar k = 0; k < N_CHAINS; k++) begin : g_sync
        apuf_sync2 u_sync (
            .clk (Clk),
            .rst (Rst),
            .d   (Arb_in[k]),
            .q   (arb_sync[k])
        );
    end

    // Chain k sees the latched challenge rotated left by k bits.
    always_comb begin
        Chain_challenge = '0;
        for (int k = 0; k < N_CHAINS; k++) begin
            Chain_challenge[k*C_LENGTH +: C_LENGTH] =
                (challenge_q << k) | (challenge_q >> (C_LENGTH - k));
        end
    end

`ifdef APUF_MAJORITY_VOTE_EN
    localparam int VOTE_W = clog2(N_EVAL + 1);

    logic [VOTE_W-1:0]                eval_q, eval_d;
    logic [N_CHAINS-1:0][VOTE_W-1:0]  vote_q, vote_d;
    logic [N_CHAINS-1:0][VOTE_W-1:0]  vote_sum;

    // The final vote includes the bit being sampled in the current cycle.
    always_comb begin
        vote_sum  = '0;
        vote_bits = '0;
        for (int k = 0; k < N_CHAINS; k++) begin
            vote_sum[k]  = vote_q[k] + VOTE_W'(arb_sync[k]);
            vote_bits[k] = (vote_sum[k] > VOTE_W'(N_EVAL / 2));
        end
        last_eval = (eval_q == VOTE_W'(N_EVAL - 1));
    end
`else
    always_comb begin
        vote_bits = arb_sync;
        last_eval = 1'b1;
    end
`endif

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        challenge_d = challenge_q;
        mode_d      = mode_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        launch_d    = launch_q;
        response_d  = response_q;
`ifdef APUF_MAJORITY_VOTE_EN
        eval_d      = eval_q;
        vote_d      = vote_q;
`endif
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d     = ARM;
                    phase_d     = '0;
                    challenge_d = Challenge;
                    mode_d      = Mode;
                    busy_d      = 1'b1;
`ifdef APUF_MAJORITY_VOTE_EN
                    eval_d      = '0;
                    vote_d      = '0;
`endif
                end
            end
            ARM: begin
                if (phase_q == PHASE_LAST) begin
                    state_d  = FIRE;
                    phase_d  = '0;
                    launch_d = 1'b1;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            FIRE: begin
                if (phase_q == PHASE_LAST) begin
                    phase_d  = '0;
                    launch_d = 1'b0;
`ifdef APUF_MAJORITY_VOTE_EN
                    eval_d   = eval_q + 1'b1;
                    vote_d   = vote_sum;
`endif
                    if (last_eval) begin
                        state_d    = DONE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        response_d = mode_q ? N_CHAINS'(^vote_bits) : vote_bits;
                    end else begin
                        state_d = ARM;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            challenge_q <= '0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            launch_q    <= 1'b0;
            response_q  <= '0;
`ifdef APUF_MAJORITY_VOTE_EN
            eval_q      <= '0;
            vote_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            challenge_q <= challenge_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            launch_q    <= launch_d;
            response_q  <= response_d;
`ifdef APUF_MAJORITY_VOTE_EN
            eval_q      <= eval_d;
            vote_q      <= vote_d;
`endif
        end
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Launch   = launch_q;
    assign Response = response_q;

endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Bench for apuf_eval_ctrl with a parity-based delay-chain model and a
// timeline-level reference; build with APUF_MAJORITY_VOTE_EN for the voting variant.
`timescale 1ns/1ps
module tb_apuf_eval_ctrl;

    localparam int CL     = 8;
    localparam int NC     = 4;
    localparam int SC     = 4;
    localparam int NE     = 5;
    localparam int PERIOD = 2 * SC;
`ifdef APUF_MAJORITY_VOTE_EN
    localparam int E        = NE;
    localparam int DONE_OFS = 41;
`else
    localparam int E        = 1;
    localparam int DONE_OFS = 9;
`endif

    logic             Clk = 1'b0;
    logic             Rst;
    logic             Start;
    logic             Mode;
    logic [CL-1:0]    Challenge;
    logic             Busy;
    logic             Done;
    logic [NC-1:0]    Response;
    logic             Launch;
    logic [NC*CL-1:0] Chain_challenge;
    logic [NC-1:0]    Arb_in = '0;

    apuf_eval_ctrl #(
        .C_LENGTH      (CL),
        .N_CHAINS      (NC),
        .SETTLE_CYCLES (SC),
        .N_EVAL        (NE)
    ) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Start           (Start),
        .Mode            (Mode),
        .Challenge       (Challenge),
        .Busy            (Busy),
        .Done            (Done),
        .Response        (Response),
        .Launch          (Launch),
        .Chain_challenge (Chain_challenge),
        .Arb_in          (Arb_in)
    );

    always #5 Clk = ~Clk;

    int            cyc       = 0;
    int            errors    = 0;
    int            checks    = 0;
    int            doneCount = 0;
    bit            mActive   = 1'b0;
    int            mT0       = 0;
    logic [CL-1:0] mCh       = '0;
    logic [NC-1:0] mResp     = '0;
    logic [NC-1:0] mPending  = '0;
    logic [NC-1:0] flipTab [8];

    function automatic logic [CL-1:0] rotl(input logic [CL-1:0] ch, input int k);
        int v;
        v = int'(ch);
        return CL'(((v << k) | (v >> (CL - k))) & ((1 << CL) - 1));
    endfunction

    function automatic logic [NC*CL-1:0] chainExp(input logic [CL-1:0] ch);
        logic [NC*CL-1:0] r;
        r = '0;
        for (int k = 0; k < NC; k++) r = r | ((NC*CL)'(rotl(ch, k)) << (k * CL));
        return r;
    endfunction

    // Majority over E evaluations of each chain's parity, with the bench's per-evaluation flips.
    function automatic logic [NC-1:0] expectedResponse(input logic [CL-1:0] ch, input bit md);
        logic [NC-1:0] votes;
        int            cnt;
        int            ones;
        votes = '0;
        for (int k = 0; k < NC; k++) begin
            cnt = 0;
            for (int e = 0; e < E; e++) begin
                cnt = cnt + (($countones(rotl(ch, k)) + int'(flipTab[e][k])) % 2);
            end
            votes[k] = (cnt > E / 2);
        end
        ones = $countones(votes);
        return md ? NC'(ones % 2) : votes;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Delay-chain environment plus reference timeline, both advanced once per clock.
    always @(posedge Clk) begin
        int            c;
        int            e;
        logic [CL-1:0] slice;
        logic [NC-1:0] nextArb;
        c = cyc;
        e = mActive ? (c - mT0 - 1) / PERIOD : 0;
        if (e < 0 || e > 7) e = 0;
        for (int k = 0; k < NC; k++) begin
            slice      = Chain_challenge[k*CL +: CL];
            nextArb[k] = Launch & ((^slice) ^ flipTab[e][k]);
        end
        Arb_in <= nextArb;

        if (Rst) begin
            mActive = 1'b0;
            mResp   = '0;
            mCh     = '0;
        end else begin
            if (mActive && c == mT0 + E * PERIOD) mResp = mPending;
            if (mActive && c == mT0 + 1 + E * PERIOD) begin
                mActive = 1'b0;
            end else if (!mActive && Start) begin
                mActive  = 1'b1;
                mT0      = c;
                mCh      = Challenge;
                mPending = expectedResponse(Challenge, Mode);
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge Clk) begin
        bit busyExp;
        bit doneExp;
        bit launchExp;
        if (cyc >= 1) begin
            busyExp   = mActive && cyc >= mT0 + 1 && cyc <= mT0 + E * PERIOD;
            doneExp   = mActive && cyc == mT0 + 1 + E * PERIOD;
            launchExp = busyExp && ((cyc - mT0 - 1) % PERIOD) >= SC;
            checkOutput("busy", 64'(Busy), 64'(busyExp));
            checkOutput("done", 64'(Done), 64'(doneExp));
            checkOutput("launch", 64'(Launch), 64'(launchExp));
            checkOutput("response", 64'(Response), 64'(mResp));
            checkOutput("chain_challenge", 64'(Chain_challenge), 64'(chainExp(mCh)));
            if (Done === 1'b1) doneCount++;
        end
    end

    task automatic applyStimulus(input bit st, input bit md, input logic [CL-1:0] ch,
                                 input bit rs, output int tDrive);
        tDrive    = cyc;
        Start     = st;
        Mode      = md;
        Challenge = ch;
        Rst       = rs;
        @(negedge Clk);
        Start = 1'b0;
        Rst   = 1'b0;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge Clk);
    endtask

    task automatic clearFlips();
        for (int e = 0; e < 8; e++) flipTab[e] = '0;
    endtask

    task automatic runOne(input bit md, input logic [CL-1:0] ch, input logic [NC-1:0] exp,
                          input string name);
        int t;
        applyStimulus(1'b1, md, ch, 1'b0, t);
        waitUntil(t + DONE_OFS);
        checkOutput({name, "_done"}, 64'(Done), 64'd1);
        checkOutput({name, "_resp"}, 64'(Response), 64'(exp));
        @(negedge Clk);
    endtask

    initial begin
        int t;
        int t2;
        int dc;
        int guard;
        Rst = 1'b1; Start = 1'b0; Mode = 1'b0; Challenge = '0;
        clearFlips();
        repeat (3) @(negedge Clk);
        checkOutput("reset_busy", 64'(Busy), 64'd0);
        checkOutput("reset_launch", 64'(Launch), 64'd0);
        checkOutput("reset_resp", 64'(Response), 64'd0);
        checkOutput("reset_chain", 64'(Chain_challenge), 64'd0);
        Rst = 1'b0;
        @(negedge Clk);

        // Basic evaluation; Challenge/Mode are disturbed while busy and must not matter.
        applyStimulus(1'b1, 1'b0, 8'h01, 1'b0, t);
        waitUntil(t + 1);
        checkOutput("A_busy", 64'(Busy), 64'd1);
        checkOutput("A_chain", 64'(Chain_challenge), 64'h08040201);
        Challenge = 8'hFF;
        Mode      = 1'b1;
        waitUntil(t + 4);
        checkOutput("A_launch_arm", 64'(Launch), 64'd0);
        waitUntil(t + 5);
        checkOutput("A_launch_first", 64'(Launch), 64'd1);
        waitUntil(t + 8);
        checkOutput("A_launch_last", 64'(Launch), 64'd1);
        checkOutput("A_chain_held", 64'(Chain_challenge), 64'h08040201);
        waitUntil(t + 9);
        checkOutput("A_launch_end", 64'(Launch), 64'd0);
        waitUntil(t + DONE_OFS);
        checkOutput("A_done", 64'(Done), 64'd1);
        checkOutput("A_resp", 64'(Response), 64'hF);
        waitUntil(t + DONE_OFS + 1);
        checkOutput("A_done_pulse", 64'(Done), 64'd0);
        checkOutput("A_resp_hold", 64'(Response), 64'hF);

        runOne(1'b1, 8'h03, 4'b0000, "B_xor03");
        runOne(1'b1, 8'h07, 4'b0000, "B_xor07");
        for (int e = 0; e < 8; e++) flipTab[e] = 4'b0001;
        runOne(1'b1, 8'h01, 4'b0001, "B_xor_flip0");
        for (int e = 0; e < 8; e++) flipTab[e] = 4'b1000;
        runOne(1'b0, 8'h03, 4'b1000, "B_vec_flip3");
        clearFlips();

`ifdef APUF_MAJORITY_VOTE_EN
        flipTab[1] = 4'b0100;
        flipTab[3] = 4'b0100;
        runOne(1'b0, 8'h01, 4'b1111, "C_vote_3of5");
        clearFlips();
        flipTab[0] = 4'b0010;
        flipTab[1] = 4'b0010;
        flipTab[2] = 4'b0010;
        runOne(1'b0, 8'h01, 4'b1101, "C_vote_2of5");
        clearFlips();
`endif

        // Start while busy and in the DONE cycle is ignored; the following cycle is accepted.
        dc = doneCount;
        applyStimulus(1'b1, 1'b0, 8'h01, 1'b0, t);
        waitUntil(t + 3);
        applyStimulus(1'b1, 1'b1, 8'h03, 1'b0, t2);
        waitUntil(t + DONE_OFS);
        applyStimulus(1'b1, 1'b0, 8'h03, 1'b0, t2);
        checkOutput("D_busy_after_done_start", 64'(Busy), 64'd0);
        checkOutput("D_one_done", 64'(doneCount - dc), 64'd1);
        checkOutput("D_resp", 64'(Response), 64'hF);
        applyStimulus(1'b1, 1'b0, 8'h03, 1'b0, t2);
        checkOutput("D_restart_busy", 64'(Busy), 64'd1);
        waitUntil(t2 + DONE_OFS + 1);
        checkOutput("D_restart_resp", 64'(Response), 64'h0);
        checkOutput("D_two_dones", 64'(doneCount - dc), 64'd2);

        // Reset during FIRE aborts without Done and clears Response.
        runOne(1'b0, 8'h01, 4'b1111, "E_prep");
        dc = doneCount;
        applyStimulus(1'b1, 1'b0, 8'h01, 1'b0, t);
        waitUntil(t + 6);
        applyStimulus(1'b0, 1'b0, 8'h01, 1'b1, t2);
        checkOutput("E_launch", 64'(Launch), 64'd0);
        checkOutput("E_busy", 64'(Busy), 64'd0);
        checkOutput("E_resp", 64'(Response), 64'd0);
        waitUntil(t + DONE_OFS + 3);
        checkOutput("E_no_done", 64'(doneCount - dc), 64'd0);
        runOne(1'b0, 8'h01, 4'b1111, "E_after");

        for (int it = 0; it < 25; it++) begin
            for (int e = 0; e < 8; e++)
                flipTab[e] = ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0;
            applyStimulus(1'b1, 1'($urandom), CL'($urandom), 1'b0, t);
            guard = 0;
            while (mActive && guard < 200) begin
                Start     = ($urandom_range(0, 5) == 0);
                Challenge = CL'($urandom);
                Mode      = 1'($urandom);
                @(negedge Clk);
                guard++;
            end
            Start = 1'b0;
            checks++;
            if (guard >= 200) begin
                errors++;
                $display("[TB] FAIL rand_timeout: got busy after %0d cycles, expected done", guard);
            end
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end

        repeat (2) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish within 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
